// File: rtl/jk_excite_ctrl.sv
// Drive-side controller for a bank of negedge-triggered JK flip-flops with async preset/clear.
// Keeps a shadow of the bank, derives per-bit J/K excitation, and sequences the bank clock
// strobe and the preset/clear pulses with programmable setup and hold spacing.
// Optional feature: define JK_EXC_VERIFY_EN to compare the bank readback (q_fb) against the
// expected shadow at the end of each command, flag a sticky err, and resync the shadow.
module jk_excite_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_target,
  output logic             ff_clk,
  output logic [WIDTH-1:0] ff_j,
  output logic [WIDTH-1:0] ff_k,
  output logic             ff_preset,
  output logic             ff_clear,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] q_state,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntMax = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {StInit, StIdle, StSetup, StStrobe, StHold} state_e;
  typedef enum logic [1:0] {
    CmdLoad   = 2'b00,
    CmdPreset = 2'b01,
    CmdClear  = 2'b10,
    CmdToggle = 2'b11
  } cmd_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             in_ready_q, in_ready_d;
  logic             ff_clk_q, ff_clk_d;
  logic [WIDTH-1:0] ff_j_q, ff_j_d;
  logic [WIDTH-1:0] ff_k_q, ff_k_d;
  logic             ff_preset_q, ff_preset_d;
  logic             ff_clear_q, ff_clear_d;
  logic [WIDTH-1:0] q_state_q, q_state_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  cmd_e             in_cmd_e;
  logic             strobe_cmd;
  logic [WIDTH-1:0] shadow_exp;
  logic [WIDTH-1:0] shadow_new;
  logic             fb_mismatch;

  assign in_cmd_e   = cmd_e'(in_cmd);
  // Only LOAD and TOGGLE clock the bank; PRESET/CLEAR act through the async pins.
  assign strobe_cmd = (cmd_q == CmdLoad) || (cmd_q == CmdToggle);

  // Shadow value the bank should hold once the latched command completes.
  always_comb begin
    shadow_exp = q_state_q;
    unique case (cmd_q)
      CmdLoad:   shadow_exp = target_q;
      CmdPreset: shadow_exp = '1;
      CmdClear:  shadow_exp = '0;
      CmdToggle: shadow_exp = ~q_state_q;
      default:   shadow_exp = q_state_q;
    endcase
  end

`ifdef JK_EXC_VERIFY_EN
  // Readback wins on mismatch so the shadow tracks what the bank really holds.
  assign fb_mismatch = (q_fb != shadow_exp);
  assign shadow_new  = fb_mismatch ? q_fb : shadow_exp;
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign fb_mismatch = 1'b0;
  assign shadow_new  = shadow_exp;
`endif

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    target_d    = target_q;
    in_ready_d  = in_ready_q;
    ff_clk_d    = ff_clk_q;
    ff_j_d      = ff_j_q;
    ff_k_d      = ff_k_q;
    ff_preset_d = ff_preset_q;
    ff_clear_d  = ff_clear_q;
    q_state_d   = q_state_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StInit: begin
        state_d    = StIdle;
        in_ready_d = 1'b1;
        ff_clear_d = 1'b0;
        ff_clk_d   = 1'b1;
      end
      StIdle: begin
        if (in_valid && in_ready_q) begin
          state_d     = StSetup;
          cnt_d       = '0;
          cmd_d       = in_cmd_e;
          target_d    = in_target;
          in_ready_d  = 1'b0;
          ff_clk_d    = 1'b1;
          ff_preset_d = (in_cmd_e == CmdPreset);
          ff_clear_d  = (in_cmd_e == CmdClear);
          // Minimal excitation: set where 0->1, reset where 1->0, don't-cares at 0.
          unique case (in_cmd_e)
            CmdLoad: begin
              ff_j_d = ~q_state_q & in_target;
              ff_k_d = q_state_q & ~in_target;
            end
            CmdToggle: begin
              ff_j_d = '1;
              ff_k_d = '1;
            end
            default: begin
              ff_j_d = '0;
              ff_k_d = '0;
            end
          endcase
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d  = StStrobe;
          cnt_d    = '0;
          ff_clk_d = ~strobe_cmd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          ff_clk_d    = 1'b1;
          ff_j_d      = '0;
          ff_k_d      = '0;
          ff_preset_d = 1'b0;
          ff_clear_d  = 1'b0;
          q_state_d   = shadow_new;
          done_d      = 1'b1;
          err_d       = err_q | fb_mismatch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and output registers; clear forces INIT, which also clears the bank.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      cmd_q       <= CmdLoad;
      target_q    <= '0;
      in_ready_q  <= 1'b0;
      ff_clk_q    <= 1'b1;
      ff_j_q      <= '0;
      ff_k_q      <= '0;
      ff_preset_q <= 1'b0;
      ff_clear_q  <= 1'b1;
      q_state_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      target_q    <= target_d;
      in_ready_q  <= in_ready_d;
      ff_clk_q    <= ff_clk_d;
      ff_j_q      <= ff_j_d;
      ff_k_q      <= ff_k_d;
      ff_preset_q <= ff_preset_d;
      ff_clear_q  <= ff_clear_d;
      q_state_q   <= q_state_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ff_clk    = ff_clk_q;
  assign ff_j      = ff_j_q;
  assign ff_k      = ff_k_q;
  assign ff_preset = ff_preset_q;
  assign ff_clear  = ff_clear_q;
  assign q_state   = q_state_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: instance A (default timing) runs directed and random commands
// against a command-level reference and a behavioural JK bank; instance B (setup 2, hold 3)
// checks back-to-back acceptance spacing. Honours JK_EXC_VERIFY_EN when defined.
module tb_jk_excite_ctrl;

  localparam int SA = 1;
  localparam int HA = 1;
  localparam int SB = 2;
  localparam int HB = 3;
  localparam logic [1:0] LOAD = 2'b00, PRESET = 2'b01, CLEARC = 2'b10, TOGGLE = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic       clear_a, in_valid_a, in_ready_a, ff_clk_a, ff_preset_a, ff_clear_a, done_a, err_a;
  logic [1:0] in_cmd_a;
  logic [7:0] in_target_a, ff_j_a, ff_k_a, q_fb_a, q_state_a, bank_a, fb_val;
  logic       fb_force;

  // Instance B signals
  logic       clear_b, in_valid_b, in_ready_b, ff_clk_b, ff_preset_b, ff_clear_b, done_b, err_b;
  logic [1:0] in_cmd_b;
  logic [7:0] in_target_b, ff_j_b, ff_k_b, q_fb_b, q_state_b, bank_b;

  assign q_fb_a = fb_force ? fb_val : bank_a;
  assign q_fb_b = bank_b;

  jk_excite_ctrl #(.WIDTH(8), .SETUP_CYC(SA), .HOLD_CYC(HA)) u_dut_a (
    .clk(clk), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_cmd(in_cmd_a), .in_target(in_target_a), .ff_clk(ff_clk_a), .ff_j(ff_j_a),
    .ff_k(ff_k_a), .ff_preset(ff_preset_a), .ff_clear(ff_clear_a), .q_fb(q_fb_a),
    .q_state(q_state_a), .done(done_a), .err(err_a)
  );

  jk_excite_ctrl #(.WIDTH(8), .SETUP_CYC(SB), .HOLD_CYC(HB)) u_dut_b (
    .clk(clk), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_cmd(in_cmd_b), .in_target(in_target_b), .ff_clk(ff_clk_b), .ff_j(ff_j_b),
    .ff_k(ff_k_b), .ff_preset(ff_preset_b), .ff_clear(ff_clear_b), .q_fb(q_fb_b),
    .q_state(q_state_b), .done(done_b), .err(err_b)
  );

  // Behavioural JK banks: negedge clocked, async clear over preset.
  always @(negedge ff_clk_a or posedge ff_preset_a or posedge ff_clear_a) begin
    if (ff_clear_a)       bank_a <= 8'h00;
    else if (ff_preset_a) bank_a <= 8'hFF;
    else                  bank_a <= (ff_j_a & ~bank_a) | (~ff_k_a & bank_a);
  end

  always @(negedge ff_clk_b or posedge ff_preset_b or posedge ff_clear_b) begin
    if (ff_clear_b)       bank_b <= 8'h00;
    else if (ff_preset_b) bank_b <= 8'hFF;
    else                  bank_b <= (ff_j_b & ~bank_b) | (~ff_k_b & bank_b);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference state for instance A
  logic [7:0] shadow = 8'h00;
  logic       err_exp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on A and check every cycle until completion against the reference.
  task automatic do_cmd(input logic [1:0] cmd, input logic [7:0] tgt);
    int         n;
    logic [7:0] j_exp, k_exp, new_exp, fb_snap, old;
    logic       strobe, ck_exp;
    n = SA + HA + 2;
    for (int w = 0; w < 20 && !in_ready_a; w++) tick();
    chk1("ready_before_cmd", in_ready_a, 1'b1);
    old = shadow;
    strobe = (cmd == LOAD) || (cmd == TOGGLE);
    j_exp = 8'h00;
    k_exp = 8'h00;
    if (cmd == LOAD) begin
      j_exp = ~old & tgt;
      k_exp = old & ~tgt;
      new_exp = tgt;
    end else if (cmd == TOGGLE) begin
      j_exp = 8'hFF;
      k_exp = 8'hFF;
      new_exp = ~old;
    end else if (cmd == PRESET) begin
      new_exp = 8'hFF;
    end else begin
      new_exp = 8'h00;
    end
    fb_snap = 8'h00;
    in_valid_a  = 1'b1;
    in_cmd_a    = cmd;
    in_target_a = tgt;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) begin
        // Scramble the inputs so late sampling of in_cmd/in_target shows up.
        in_valid_a  = 1'b0;
        in_cmd_a    = 2'($urandom);
        in_target_a = 8'($urandom);
      end
      if (k < n) begin
        ck_exp = (strobe && k >= SA + 1) ? 1'b0 : 1'b1;
        chk1("busy_ff_clk", ff_clk_a, ck_exp);
        chk8("busy_ff_j", ff_j_a, j_exp);
        chk8("busy_ff_k", ff_k_a, k_exp);
        chk1("busy_ff_preset", ff_preset_a, cmd == PRESET);
        chk1("busy_ff_clear", ff_clear_a, cmd == CLEARC);
        chk1("busy_in_ready", in_ready_a, 1'b0);
        chk1("busy_done", done_a, 1'b0);
        chk8("busy_q_state", q_state_a, old);
        if (k == n - 1) fb_snap = q_fb_a;
      end else begin
`ifdef JK_EXC_VERIFY_EN
        if (fb_snap !== new_exp) begin
          new_exp = fb_snap;
          err_exp = 1'b1;
        end
`endif
        chk1("done_pulse", done_a, 1'b1);
        chk1("done_in_ready", in_ready_a, 1'b1);
        chk1("done_ff_clk", ff_clk_a, 1'b1);
        chk8("done_ff_j", ff_j_a, 8'h00);
        chk8("done_ff_k", ff_k_a, 8'h00);
        chk1("done_ff_preset", ff_preset_a, 1'b0);
        chk1("done_ff_clear", ff_clear_a, 1'b0);
        chk8("done_q_state", q_state_a, new_exp);
        chk1("done_err", err_a, err_exp);
      end
    end
    shadow = new_exp;
    tick();
    chk1("after_done_low", done_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         accepts, last_acc, gap;
    logic [7:0] sh_b;
    logic [1:0] rc;
    logic [7:0] rt;

    clear_a = 1'b1; in_valid_a = 1'b0; in_cmd_a = 2'b00; in_target_a = 8'h00;
    clear_b = 1'b1; in_valid_b = 1'b0; in_cmd_b = 2'b00; in_target_b = 8'h00;
    fb_force = 1'b0; fb_val = 8'h00;

    // Reset held for two cycles, then one INIT cycle, then idle.
    tick();
    chk1("rst_ff_clear", ff_clear_a, 1'b1);
    tick();
    clear_a = 1'b0;
    clear_b = 1'b0;
    chk1("init_ff_clear", ff_clear_a, 1'b1);
    chk1("init_ff_clk", ff_clk_a, 1'b1);
    chk1("init_ff_preset", ff_preset_a, 1'b0);
    chk8("init_ff_j", ff_j_a, 8'h00);
    chk8("init_ff_k", ff_k_a, 8'h00);
    chk1("init_in_ready", in_ready_a, 1'b0);
    chk1("init_done", done_a, 1'b0);
    chk1("init_err", err_a, 1'b0);
    chk8("init_q_state", q_state_a, 8'h00);
    tick();
    chk1("idle_in_ready", in_ready_a, 1'b1);
    chk1("idle_ff_clear", ff_clear_a, 1'b0);
    chk1("idle_ff_clk", ff_clk_a, 1'b1);
    chk8("idle_bank", q_fb_a, 8'h00);

    // Directed sequence from the test plan.
    do_cmd(LOAD, 8'h0F);
    do_cmd(LOAD, 8'h3C);
    chk8("load_3c_shadow", q_state_a, 8'h3C);
    do_cmd(TOGGLE, 8'h00);
    chk8("toggle_shadow", q_state_a, 8'hC3);
    do_cmd(PRESET, 8'h00);
    chk8("preset_shadow", q_state_a, 8'hFF);
    do_cmd(CLEARC, 8'h00);
    chk8("clear_shadow", q_state_a, 8'h00);

    // Readback forced to disagree with the expected shadow.
    fb_force = 1'b1;
    fb_val   = 8'hAB;
    do_cmd(LOAD, 8'hAA);
`ifdef JK_EXC_VERIFY_EN
    chk8("verify_resync", q_state_a, 8'hAB);
    chk1("verify_err", err_a, 1'b1);
`else
    chk8("noverify_shadow", q_state_a, 8'hAA);
    chk1("noverify_err", err_a, 1'b0);
`endif
    fb_force = 1'b0;
    do_cmd(CLEARC, 8'h00);

    // Random commands with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      rc  = 2'($urandom);
      rt  = 8'($urandom);
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) tick();
      do_cmd(rc, rt);
      chk8("rand_shadow_vs_bank", q_state_a, q_fb_a);
      chk1("rand_err_sticky", err_a, err_exp);
    end

    // Reset during STROBE aborts without done.
    for (int w = 0; w < 20 && !in_ready_a; w++) tick();
    chk1("abort_ready", in_ready_a, 1'b1);
    in_valid_a  = 1'b1;
    in_cmd_a    = LOAD;
    in_target_a = ~shadow;
    tick();
    in_valid_a = 1'b0;
    tick();
    chk1("abort_in_strobe", ff_clk_a, 1'b0);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    shadow  = 8'h00;
    err_exp = 1'b0;
    chk1("abort_ff_clear", ff_clear_a, 1'b1);
    chk1("abort_ff_clk", ff_clk_a, 1'b1);
    chk1("abort_ff_preset", ff_preset_a, 1'b0);
    chk8("abort_ff_j", ff_j_a, 8'h00);
    chk8("abort_ff_k", ff_k_a, 8'h00);
    chk1("abort_in_ready", in_ready_a, 1'b0);
    chk1("abort_done", done_a, 1'b0);
    chk1("abort_err", err_a, 1'b0);
    chk8("abort_q_state", q_state_a, 8'h00);
    tick();
    chk1("abort_idle_ready", in_ready_a, 1'b1);
    chk1("abort_idle_done", done_a, 1'b0);
    chk8("abort_idle_q_state", q_state_a, 8'h00);
    do_cmd(LOAD, 8'h5A);

    // Instance B: in_valid held continuously, accepts every SB+HB+2 cycles.
    accepts  = 0;
    last_acc = 0;
    sh_b     = 8'h00;
    in_cmd_b = TOGGLE;
    in_valid_b = 1'b1;
    for (int c = 0; c < 60 && accepts < 5; c++) begin
      if (in_ready_b) begin
        if (accepts > 0) begin
          chkn("b_spacing", cyc - last_acc, SB + HB + 2);
          chk1("b_done_with_accept", done_b, 1'b1);
          sh_b = ~sh_b;
          chk8("b_shadow", q_state_b, sh_b);
          chk1("b_err", err_b, 1'b0);
        end else begin
          chk1("b_first_no_done", done_b, 1'b0);
        end
        last_acc = cyc;
        accepts++;
      end else begin
        chk1("b_busy_no_done", done_b, 1'b0);
      end
      tick();
    end
    in_valid_b = 1'b0;
    chkn("b_accept_count", accepts, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excite_ctrl.md
# jk_excite_ctrl

Drive-side controller for a bank of negedge-triggered JK flip-flops with async preset/clear, i.e. the `jk_ff` cells in this codebase. Accepts target words or commands over a valid/ready handshake. Keeps a shadow copy of the bank state and computes per-bit J/K excitation from the shadow and the target. Generates the flip-flop clock strobe, plus preset/clear pulses, with programmable setup and hold spacing.

## Interface
- `WIDTH`, 8, number of flip-flops in the driven bank (≥1)
- `SETUP_CYC`, 1, cycles J/K are stable with `ff_clk` high before the falling edge (≥1)
- `HOLD_CYC`, 1, cycles J/K are held after the falling edge (≥1)

Ports:
- `clk` in 1: system clock; all logic on its rising edge
- `clear` in 1: reset, synchronous, active-high
- `in_valid` in 1: command/target valid
- `in_ready` out 1: block idle, can accept a command
- `in_cmd` in 2: 00 LOAD, 01 PRESET, 10 CLEAR, 11 TOGGLE
- `in_target` in WIDTH: desired bank state; used by LOAD only
- `ff_clk` out 1: clock strobe to the bank; only falling edge is significant
- `ff_j` out WIDTH: J inputs to the bank
- `ff_k` out WIDTH: K inputs to the bank
- `ff_preset` out 1: preset to all bank flip-flops
- `ff_clear` out 1: clear to all bank flip-flops
- `q_fb` in WIDTH: Q readback from the bank
- `q_state` out WIDTH: shadow of the bank state
- `done` out 1: one-cycle pulse, command completed
- `err` out 1: sticky readback mismatch

## Operation
- All outputs are registered.
- FSM states: INIT, IDLE, SETUP, STROBE, HOLD.
- Reset value (cycle after `clear` is sampled high):
  - state INIT; `ff_clear`=1, `ff_preset`=0, `ff_clk`=1, `ff_j`=`ff_k`=0
  - `in_ready`=0, `done`=0, `err`=0, `q_state`=0
- INIT lasts one cycle, then IDLE. Purpose: the bank is cleared to match the shadow.
- IDLE: `in_ready`=1, `ff_clk`=1, J/K=0, `ff_preset`=`ff_clear`=0.
  - Handshake: `in_valid && in_ready` latches `in_cmd`/`in_target` and moves to SETUP.
  - `in_valid` while `in_ready`=0 is ignored; the source must hold it.
- LOAD excitation per bit i, with s=`q_state[i]`, t=`in_target[i]`:
  - s=0, t=0: J=0, K=0
  - s=0, t=1: J=1, K=0
  - s=1, t=0: J=0, K=1
  - s=1, t=1: J=0, K=0
  - Don't-care outputs are driven 0.
- TOGGLE: J=K=all ones.
- PRESET/CLEAR: J=K=0, `ff_clk` stays 1 throughout; `ff_preset`/`ff_clear` asserted for the whole of SETUP+STROBE+HOLD.
- SETUP: SETUP_CYC cycles, `ff_clk`=1, J/K driven.
- STROBE: one cycle, `ff_clk`=0 (LOAD/TOGGLE only); J/K held.
- HOLD: HOLD_CYC cycles, `ff_clk`=0 (LOAD/TOGGLE), J/K held.
- Shadow update on HOLD exit:
  - LOAD: `q_state`←target
  - TOGGLE: `q_state`←~`q_state`
  - PRESET: `q_state`←all ones
  - CLEAR: `q_state`←0
- Return to IDLE with `done`=1 for one cycle. J/K return to 0 and `ff_clk` to 1 in the same cycle.
- `clear` mid-command: abort immediately, all outputs to reset values, enter INIT. No `done` is issued for the aborted command.

## Timing
- Accept in cycle T.
- SETUP occupies T+1 … T+SETUP_CYC.
- STROBE at T+SETUP_CYC+1; this is the `ff_clk` falling edge.
- HOLD follows, HOLD_CYC cycles.
- `done` and `in_ready`=1 both occur at T+SETUP_CYC+HOLD_CYC+2. With defaults: `done` at T+4.
- Command-to-command spacing is SETUP_CYC+HOLD_CYC+2 cycles. A new command can be accepted in the same cycle as `done`.
- `ff_clk` has exactly one falling edge per LOAD/TOGGLE and none otherwise. There are no glitches: J/K never change while `ff_clk`=0.
- `q_state` changes only in the `done` cycle, INIT, or reset.

## Configuration
- `JK_EXC_VERIFY_EN` defined:
  - In the last HOLD cycle, `q_fb` is compared with the expected new shadow.
  - On mismatch: `err` is set and stays set until `clear`. `q_state` takes `q_fb` rather than the expected value, resyncing the shadow.
- Not defined: `q_fb` is ignored, `err` is tied 0, and the shadow always takes the expected value.

## Test plan
- Reset then idle:
  - assert `clear` 2 cycles → `ff_clear`=1 for the cycle after release, `q_state`=0
  - next cycle `in_ready`=1; `ff_clk`=1 throughout
- LOAD excitation, WIDTH=8, defaults:
  - shadow 0x0F, LOAD 0x3C → `ff_j`=0x30, `ff_k`=0x03 from T+1 through T+3
  - `ff_clk` low at T+2..T+3; `done` at T+4; `q_state`=0x3C
- TOGGLE then PRESET/CLEAR:
  - TOGGLE from 0x3C → J=K=0xFF, one falling edge, `q_state`=0xC3
  - PRESET → `ff_preset` high 3 cycles, no `ff_clk` edge, `q_state`=0xFF
  - CLEAR → `q_state`=0x00
- Back-pressure and spacing:
  - hold `in_valid` continuously with SETUP_CYC=2, HOLD_CYC=3 → one command accepted every 7 cycles
  - `done` coincides with the next accept
- Reset mid-command: assert `clear` during STROBE → next cycle all outputs at reset values, no `done`, shadow 0.
- With `JK_EXC_VERIFY_EN`: LOAD 0xAA while the model forces `q_fb`=0xAB → `err`=1 (sticky), `q_state`=0xAB; without the macro `err` stays 0 and `q_state`=0xAA.
